aud_sample_fifo: RTL and testbench

- Stereo sample buffer directly upstream of the I2S transmitter, in the audio clock domain.
- Producer (synth voice mixer or CPU bridge) pushes 16-bit L/R pairs through a valid/ready handshake.
- Each single-cycle sample request from the I2S transmitter pops one pair and holds it stable on the outputs until the next request.
- Reports fill level, low-watermark, and sticky underrun/overflow status so the producer can be throttled or flagged.

---
 rtl/aud_sample_fifo.sv | 140 ++++++++++++++
 tb/tb_aud_sample_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/aud_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : aud_sample_fifo
//  Description : Stereo {left,right} sample FIFO feeding the I2S transmitter.
//                Valid/ready push side, single-cycle request pop side with
//                held outputs, registered fill level / low watermark and
//                sticky underrun / overflow status.
//  Revision    : 1.0 - initial release
// ============================================================================
module aud_sample_fifo #(
  parameter int DEPTH  = 16,
  parameter int LOW_WM = 4
) (
  input  logic                     i_aud_clk,
  input  logic                     i_aud_reset,
  input  logic                     i_wr_valid,
  input  logic [15:0]              i_wr_left,
  input  logic [15:0]              i_wr_right,
  output logic                     o_wr_ready,
  input  logic                     i_req,
  output logic [15:0]              o_left,
  output logic [15:0]              o_right,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_low,
  output logic                     o_underrun,
  output logic                     o_overflow,
  input  logic                     i_clr_status
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);
  localparam logic [c_LW-1:0] c_LOW  = c_LW'(LOW_WM);

  // Pair storage, {left,right}; contents need no reset since the pointers
  // and level define what is valid.
  logic [31:0]      mem_q [DEPTH];

  logic [c_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_LW-1:0]  level_q, level_d;
  logic             low_q, low_d;
  logic [15:0]      left_q, left_d;
  logic [15:0]      right_q, right_d;
  logic             underrun_q, underrun_d;
  logic             overflow_q, overflow_d;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_rd_pair;

  // Handshake qualification from the registered level only, so a pop in the
  // same cycle never opens a slot for a push while full.
  always_comb begin
    w_full    = (level_q == c_FULL);
    w_empty   = (level_q == '0);
    w_push    = i_wr_valid && !w_full;
    w_pop     = i_req && !w_empty;
    w_rd_pair = mem_q[rd_ptr_q];
  end

  // Next-state for pointers, level, held output pair and sticky status.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    left_d     = left_q;
    right_d    = right_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    low_d = (level_d <= c_LOW);

    // An empty request mutes rather than repeating the stale sample.
    if (i_req) begin
      left_d  = w_empty ? 16'h0000 : w_rd_pair[31:16];
      right_d = w_empty ? 16'h0000 : w_rd_pair[15:0];
    end

    // Set beats clear when both happen in the same cycle.
    underrun_d = (i_req && w_empty)      || (underrun_q && !i_clr_status);
    overflow_d = (i_wr_valid && w_full)  || (overflow_q && !i_clr_status);
  end

  // Pair storage write port.
  always_ff @(posedge i_aud_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {i_wr_left, i_wr_right};
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge i_aud_clk) begin
    if (i_aud_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      low_q      <= 1'b1;
      left_q     <= 16'h0000;
      right_q    <= 16'h0000;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      low_q      <= low_d;
      left_q     <= left_d;
      right_q    <= right_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  // Output mapping.
  always_comb begin
    o_wr_ready = !w_full;
    o_left     = left_q;
    o_right    = right_q;
    o_level    = level_q;
    o_low      = low_q;
    o_underrun = underrun_q;
    o_overflow = overflow_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_aud_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aud_sample_fifo
//  Description : Directed self-checking bench for aud_sample_fifo
//                (DEPTH=16, LOW_WM=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aud_sample_fifo;

  localparam int DEPTH  = 16;
  localparam int LOW_WM = 4;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [15:0]   wr_left;
  logic [15:0]   wr_right;
  logic          wr_ready;
  logic          req;
  logic [15:0]   left;
  logic [15:0]   right;
  logic [LW-1:0] level;
  logic          low;
  logic          underrun;
  logic          overflow;
  logic          clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aud_sample_fifo #(.DEPTH(DEPTH), .LOW_WM(LOW_WM)) dut (
    .i_aud_clk    (clk),
    .i_aud_reset  (rst),
    .i_wr_valid   (wr_valid),
    .i_wr_left    (wr_left),
    .i_wr_right   (wr_right),
    .o_wr_ready   (wr_ready),
    .i_req        (req),
    .o_left       (left),
    .o_right      (right),
    .o_level      (level),
    .o_low        (low),
    .o_underrun   (underrun),
    .o_overflow   (overflow),
    .i_clr_status (clr)
  );

  typedef struct {
    logic          v;
    logic [15:0]   l;
    logic [15:0]   r;
    logic          rq;
    logic          cl;
    logic          rs;
    int            hold;
    logic [LW-1:0] e_lvl;
    logic [15:0]   e_l;
    logic [15:0]   e_r;
    logic          e_rdy;
    logic          e_low;
    logic          e_un;
    logic          e_ov;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [15:0] h16(input int x);
    return x[15:0];
  endfunction

  function automatic logic [LW-1:0] lv(input int x);
    return x[LW-1:0];
  endfunction

  task automatic check(input string name, input logic [LW-1:0] e_lvl,
                       input logic [15:0] e_l, input logic [15:0] e_r,
                       input logic e_rdy, input logic e_low,
                       input logic e_un, input logic e_ov);
    checks++;
    if (level !== e_lvl || left !== e_l || right !== e_r || wr_ready !== e_rdy ||
        low !== e_low || underrun !== e_un || overflow !== e_ov) begin
      errors++;
      $display("FAIL %s: got lvl=%0d L=%h R=%h rdy=%b low=%b un=%b ov=%b, want lvl=%0d L=%h R=%h rdy=%b low=%b un=%b ov=%b",
               name, level, left, right, wr_ready, low, underrun, overflow,
               e_lvl, e_l, e_r, e_rdy, e_low, e_un, e_ov);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 ns after the edge.
  task automatic step(input logic v, input logic [15:0] l, input logic [15:0] r,
                      input logic rq, input logic cl, input logic rs);
    wr_valid = v;
    wr_left  = l;
    wr_right = r;
    req      = rq;
    clr      = cl;
    rst      = rs;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_left  = 16'h0000;
    wr_right = 16'h0000;
    req      = 1'b0;
    clr      = 1'b0;
    rst      = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_valid = 1'b0; wr_left = '0; wr_right = '0; req = 1'b0; clr = 1'b0;

    //          v  left      right     rq cl rs hold lvl   eL        eR       rdy low un ov
    tbl[0]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 0,  lv(0), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'h0001, 16'h8001, 1'b0, 1'b0, 1'b0, 0,  lv(1), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 16'h0002, 16'h8002, 1'b0, 1'b0, 1'b0, 0,  lv(2), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h0003, 16'h8003, 1'b0, 1'b0, 1'b0, 0,  lv(3), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 63, lv(2), 16'h0001, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 63, lv(1), 16'h0002, 16'h8002, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 5,  lv(0), 16'h0003, 16'h8003, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 0,  lv(0), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 0,  lv(0), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 0,  lv(0), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 0,  lv(0), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2,  lv(0), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].rq, tbl[i].cl, tbl[i].rs);
      check($sformatf("vec%0d", i), tbl[i].e_lvl, tbl[i].e_l, tbl[i].e_r,
            tbl[i].e_rdy, tbl[i].e_low, tbl[i].e_un, tbl[i].e_ov);
      if (tbl[i].hold > 0) begin
        for (int h = 0; h < tbl[i].hold; h++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        check($sformatf("vec%0d_hold", i), tbl[i].e_lvl, tbl[i].e_l, tbl[i].e_r,
              tbl[i].e_rdy, tbl[i].e_low, tbl[i].e_un, tbl[i].e_ov);
      end
    end

    // Fill to DEPTH, watching the low watermark and ready boundaries.
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b1, h16(32'h1000 + k), h16(32'h2000 + k), 1'b0, 1'b0, 1'b0);
      check($sformatf("fill%0d", k), lv(k + 1), 16'h0000, 16'h0000,
            (k + 1) != DEPTH, (k + 1) <= LOW_WM, 1'b0, 1'b0);
    end
    step(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    check("ovf_full", lv(16), 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("ovf_clr", lv(16), 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    // Full push+req: pop happens, push is refused.
    step(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    check("full_push_req", lv(15), 16'h1000, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < DEPTH; k++) begin
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      check($sformatf("drain%0d", k), lv(15 - k), h16(32'h1000 + k), h16(32'h2000 + k),
            1'b1, (15 - k) <= LOW_WM, 1'b0, 1'b1);
    end
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("drain_empty", lv(0), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("clr_both", lv(0), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Level 5, simultaneous push and pop across the pointer wrap.
    for (int k = 0; k < 5; k++) step(1'b1, h16(32'h3000 + k), h16(32'h4000 + k), 1'b0, 1'b0, 1'b0);
    check("lvl5", lv(5), 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step(1'b1, h16(32'h3005 + c), h16(32'h4005 + c), 1'b1, 1'b0, 1'b0);
      check($sformatf("pp%0d", c), lv(5), h16(32'h3000 + c), h16(32'h4000 + c),
            1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      check($sformatf("pp_drain%0d", k), lv(4 - k), h16(32'h3014 + k), h16(32'h4014 + k),
            1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Empty push+req: request underruns, pushed pair served next.
    step(1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0);
    check("empty_push_req", lv(1), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("empty_push_next", lv(0), 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b1, 1'b0);

    // Mid-operation reset discards stored pairs and clears status.
    for (int k = 0; k < 10; k++) step(1'b1, h16(32'h5000 + k), h16(32'h6000 + k), 1'b0, 1'b0, 1'b0);
    check("lvl10", lv(10), 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("lvl10_req", lv(9), 16'h5000, 16'h6000, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("mid_reset", lv(0), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("post_reset_req", lv(0), 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
